rr_mux8_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 8:1 one-bit selector datapath.
- Arbitrates 8 requesters that share one 8-input bit selector.
- Drives the 3-bit select and a one-hot grant.
- Returns a registered copy of the granted input bit, with a valid/ack handshake.
- Sits between the per-channel requesters and the shared output line.
- Guarantees fairness and bounded grant hold time.

---
 rtl/rr_mux8_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_mux8_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter and sequencer for a shared 8:1 one-bit selector.
// Grants one requester at a time, drives the select and one-hot grant,
// and returns a registered copy of the selected data bit with a valid flag.
// Grant hold time is bounded by HOLD_MAX (legal 1..15, 2**CNT_W > HOLD_MAX).
module rr_mux8_arbiter #(
   parameter int unsigned HOLD_MAX = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] a,
   input  logic       ack,
   output logic [7:0] gnt,
   output logic [2:0] s,
   output logic       y,
   output logic       valid
);

   localparam int unsigned N_CH  = 8;
   localparam int unsigned SEL_W = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SEL_W-1:0]      ptr_q, ptr_d;
   logic [N_CH-1:0]       gnt_d;
   logic [SEL_W-1:0]      s_d;
   logic                  y_d;
   logic                  valid_d;

   logic                  win_found;
   logic [SEL_W-1:0]      win_idx;
   logic [SEL_W-1:0]      cand;
   logic                  release_c;

   // Round-robin search: first requester at ptr, ptr+1, ... (mod 8).
   // Scanning offsets high to low lets the smallest offset win last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = '0;
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
         cand = ptr_q + SEL_W'(k);
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // End of the current grant: consumer ack, owner drops request, or hold limit.
   always_comb begin
      release_c = ack | ~req[s] | (cnt_q == CNT_LAST);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt;
      s_d     = s;
      y_d     = y;
      valid_d = valid;

      unique case (state_q)
         IDLE: begin
            gnt_d   = '0;
            valid_d = 1'b0;
            if (win_found) begin
               state_d = BUSY;
               s_d     = win_idx;
               gnt_d   = N_CH'(1) << win_idx;
               valid_d = 1'b1;
               y_d     = a[win_idx];
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (release_c) begin
               // y keeps its last loaded value on the release edge.
               state_d = IDLE;
               gnt_d   = '0;
               valid_d = 1'b0;
               ptr_d   = s + SEL_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               y_d   = a[s];
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         gnt     <= '0;
         s       <= '0;
         y       <= 1'b0;
         valid   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt     <= gnt_d;
         s       <= s_d;
         y       <= y_d;
         valid   <= valid_d;
      end
   end

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Self-checking bench for rr_mux8_arbiter: directed scenarios plus random
// traffic, compared each cycle against a transaction-level reference model.
module tb_rr_mux8_arbiter;

   localparam int HOLD_MAX = 4;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] a;
   logic       ack;
   logic [7:0] gnt;
   logic [2:0] s;
   logic       y;
   logic       valid;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the selector, for how many valid cycles so far,
   // where the next search starts, and the last data bit returned.
   bit m_busy;
   int m_owner;
   int m_run;
   int m_ptr;
   bit m_y;

   int seen_s[$];

   rr_mux8_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .a     (a),
      .ack   (ack),
      .gnt   (gnt),
      .s     (s),
      .y     (y),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_run   = 0;
      m_ptr   = 0;
      m_y     = 1'b0;
   endtask

   // One rising edge of the model, using the inputs present at that edge.
   task automatic model_edge();
      bit found;
      if (m_busy) begin
         if (ack || !req[m_owner] || m_run == HOLD_MAX) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 8;
         end else begin
            m_run++;
            m_y = a[m_owner];
         end
      end else if (req != 8'h00) begin
         found = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (!found && req[(m_ptr + k) % 8]) begin
               found   = 1'b1;
               m_owner = (m_ptr + k) % 8;
            end
         end
         m_busy = 1'b1;
         m_run  = 1;
         m_y    = a[m_owner];
      end
   endtask

   task automatic compare(input string tag);
      logic [7:0] exp_gnt;
      exp_gnt = m_busy ? (8'(1) << m_owner) : 8'h00;
      chk({tag, ".gnt"},    32'(gnt),   32'(exp_gnt));
      chk({tag, ".valid"},  32'(valid), 32'(m_busy));
      chk({tag, ".s"},      32'(s),     32'(m_owner));
      chk({tag, ".y"},      32'(y),     32'(m_y));
      chk({tag, ".onehot"}, 32'($onehot0(gnt)), 32'(1));
   endtask

   // Drive inputs away from the edge, clock once, then compare.
   task automatic cyc(input logic [7:0] r, input logic [7:0] d, input logic k, input string tag);
      req = r;
      a   = d;
      ack = k;
      @(posedge clk);
      model_edge();
      #1;
      compare(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 8'h00;
      a   = 8'h00;
      ack = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      compare("reset");
   endtask

   initial begin
      rst = 1'b1;
      req = 8'h00;
      a   = 8'h00;
      ack = 1'b0;
      model_reset();

      // 1: idle after reset with no requests
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cyc(8'h00, 8'($urandom), 1'b0, "idle");
         chk("idle.gnt_zero", 32'(gnt), 32'h0);
         chk("idle.y_zero",   32'(y),   32'h0);
      end

      // 2: single requester, ack on the second valid cycle
      do_reset();
      cyc(8'h04, 8'h04, 1'b0, "single1");
      chk("single.gnt", 32'(gnt), 32'h04);
      chk("single.s",   32'(s),   32'd2);
      chk("single.y",   32'(y),   32'd1);
      cyc(8'h04, 8'h04, 1'b0, "single2");
      chk("single.valid2", 32'(valid), 32'd1);
      cyc(8'h04, 8'h04, 1'b1, "single3");
      chk("single.rel", 32'(valid), 32'd0);
      cyc(8'h00, 8'h00, 1'b0, "single4");

      // 3: all requesting, ack every cycle -> grants walk 0..7 and wrap
      do_reset();
      seen_s.delete();
      for (int i = 0; i < 20; i++) begin
         cyc(8'hFF, 8'($urandom), 1'b1, "rr");
         if (valid) seen_s.push_back(int'(s));
      end
      chk("rr.count", 32'(seen_s.size()), 32'd10);
      foreach (seen_s[i]) chk("rr.order", 32'(seen_s[i]), 32'(i % 8));

      // 4: timeout with no ack, data toggling
      do_reset();
      seen_s.delete();
      for (int i = 0; i < 11; i++) begin
         cyc(8'h81, (i % 2 == 1) ? 8'hFF : 8'h00, 1'b0, "tmo");
         if (valid) seen_s.push_back(int'(s));
      end
      chk("tmo.count", 32'(seen_s.size()), 32'd9);
      foreach (seen_s[i]) chk("tmo.order", 32'(seen_s[i]), (i < 4 || i == 8) ? 32'd0 : 32'd7);

      // 5: owner drops its request on the second valid cycle
      do_reset();
      cyc(8'h20, 8'hFF, 1'b0, "drop1");
      chk("drop.s5", 32'(s), 32'd5);
      cyc(8'h20, 8'hFF, 1'b0, "drop2");
      cyc(8'h41, 8'hFF, 1'b0, "drop3");
      chk("drop.rel", 32'(gnt), 32'h0);
      cyc(8'h41, 8'hFF, 1'b0, "drop4");
      chk("drop.next", 32'(s), 32'd6);

      // 6: asynchronous reset in the middle of a grant
      do_reset();
      cyc(8'h08, 8'h08, 1'b0, "mid1");
      chk("mid.s3", 32'(s), 32'd3);
      chk("mid.y1", 32'(y), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      chk("mid.gnt", 32'(gnt),   32'h0);
      chk("mid.val", 32'(valid), 32'h0);
      chk("mid.s",   32'(s),     32'h0);
      chk("mid.y",   32'(y),     32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(8'h18, 8'h00, 1'b0, "mid2");
      chk("mid.first", 32'(s), 32'd3);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 500; i++) begin
         logic [7:0] r;
         r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) r = 8'h00;
         else if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
         cyc(r, 8'($urandom), ($urandom_range(0, 3) == 0), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
